pc_sequencer: RTL
=================

# pc_sequencer

Fetch-side controller for the program counter register. It owns the PC value and decides the next PC each fetch: sequential +4, a branch/jump redirect, or, optionally, a trap vector. It runs the request/acknowledge handshake to instruction memory and holds the fetched instruction for decode until decode is no longer stalled. It sits between the PC register's next-value input and the decode stage.

## Interface
- RESET_VEC, 32'h0000_0000, PC loaded on reset; low two bits must be 0
- TRAP_VEC, 32'h0000_0100, trap entry address; low two bits must be 0; used only with trap support
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low
- stall  in  1  decode cannot accept; holds the current instruction
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_target  in  32  new PC when redirect_valid=1
- halt  in  1  stop fetching after the current instruction is consumed
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address; always equals pc
- imem_ack  in  1  memory has returned data this cycle
- imem_rdata  in  32  instruction word, valid with imem_ack
- instr_valid  out  1  instr/instr_pc hold a valid instruction
- instr  out  32  fetched instruction
- instr_pc  out  32  address of instr
- misalign  out  1  one-cycle pulse: redirect/trap target had nonzero bits [1:0]
- trap  in  1  take trap; present only with PC_SEQ_TRAP_EN
- epc  out  32  PC of the instruction held when the trap was taken; present only with PC_SEQ_TRAP_EN

## Operation
- States: IDLE, REQ, HOLD, HALTED.
- IDLE: entered on reset. No request. Moves to REQ on the next clock.
- REQ: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, instr_pc<=pc, go to HOLD. If a flush is pending, discard the data, set pc<=pending target, clear the pending flag, and stay in REQ. imem_req stays high until ack; requests are never cancelled.
- HOLD: instr_valid=1.
  - Redirect: pc<=target, go to REQ, instr_valid=0. Redirect overrides stall.
  - Else if stall=1: hold everything.
  - Else if halt=1: go to HALTED.
  - Else: pc<=pc+4, go to REQ.
- Redirect in REQ before ack: latch the target as a pending flush. A later redirect before ack overwrites it.
- HALTED: no requests, instr_valid=0. Exits only on reset.
- Next-PC priority: trap > redirect > stall hold > sequential.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- Targets with bits [1:0]≠0 load with bits [1:0] forced to 00 and pulse misalign.

## Timing
- Reset values: pc=RESET_VEC, state=IDLE, imem_req=0, imem_addr=RESET_VEC, instr_valid=0, instr=0, instr_pc=0, misalign=0, epc=0.
- First imem_req is in the second rising edge's cycle after rst deasserts (IDLE lasts one cycle).
- With a zero-wait memory (ack in the same cycle as req), the block accepts one instruction every 2 cycles; each wait cycle adds 1.
- instr_valid rises the cycle after the ack edge.
- A redirect in HOLD drives imem_addr=target in the next cycle.
- Reset mid-fetch: all state clears immediately. An ack arriving during reset is ignored.

## Configuration
- PC_SEQ_TRAP_EN defined:
  - trap and epc ports exist.
  - trap=1 in any state except HALTED: pc<=TRAP_VEC, state<=REQ (or pending flush if in REQ before ack), epc<=instr_pc, instr_valid<=0.
  - trap beats redirect in the same cycle.
- PC_SEQ_TRAP_EN undefined: no trap or epc ports, no trap logic. Only redirect and sequential sources exist.

## Test plan
- Reset release with zero-wait memory returning 32'h0000_0013: first req at addr 0, then 4, then 8; instr_valid every 2nd cycle; instr_pc=0,4,8.
- Stall held 3 cycles in HOLD at pc=8: instr_valid stays 1, instr_pc=8, no imem_req; after stall drops, next addr=12.
- Redirect to 32'h0000_0040 while waiting 2 cycles for ack at pc=12: returned word is discarded, instr_valid never rises for 12, next req addr=0x40.
- Redirect to 32'h0000_0042: misalign pulses 1 cycle, next addr=32'h0000_0040.
- pc=32'hFFFF_FFFC consumed with no stall: next addr=0. With halt=1 on a consumed instruction: state HALTED, imem_req stays 0 for 10 cycles.
- (PC_SEQ_TRAP_EN) trap and redirect asserted together in HOLD at instr_pc=0x20: next addr=0x100, epc=0x20.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, runs the imem req/ack handshake and holds the fetched word for decode.
// Define PC_SEQ_TRAP_EN to add the trap input, epc output and TRAP_VEC entry.
module pc_sequencer #(
  localparam int unsigned XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000
`ifdef PC_SEQ_TRAP_EN
  , parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            halt,
`ifdef PC_SEQ_TRAP_EN
  input  logic            trap,
  output logic [XLEN-1:0] epc,
`endif
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            misalign
);

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_next;
  logic              flush_pending;
  logic              flush_pending_next;
  logic [XLEN-1:0]   flush_target;
  logic [XLEN-1:0]   flush_target_next;
  logic [XLEN-1:0]   instr_next;
  logic [XLEN-1:0]   instr_pc_next;
  logic              misalign_next;
  logic              imem_req_next;
  logic              instr_valid_next;

  logic              trap_take;
  logic              tgt_valid;
  logic [XLEN-1:0]   tgt_raw;
  logic [XLEN-1:0]   tgt_aligned;
  logic              tgt_misaligned;

  // Redirect source select: a trap (when built in) always wins over a branch redirect
`ifdef PC_SEQ_TRAP_EN
  assign trap_take = trap && (state != ST_HALTED);
  assign tgt_raw   = trap_take ? TRAP_VEC : redirect_target;
`else
  assign trap_take = 1'b0;
  assign tgt_raw   = redirect_target;
`endif

  assign tgt_valid      = trap_take || redirect_valid;
  assign tgt_aligned    = {tgt_raw[XLEN-1:2], 2'b00};
  assign tgt_misaligned = (tgt_raw[1:0] != 2'b00);
  assign imem_addr      = pc;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        state_next = ST_REQ;
      end
      ST_REQ: begin
        if (imem_ack && !tgt_valid && !flush_pending) begin
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tgt_valid) begin
          state_next = ST_REQ;
        end else if (stall) begin
          state_next = ST_HOLD;
        end else if (halt) begin
          state_next = ST_HALTED;
        end else begin
          state_next = ST_REQ;
        end
      end
      ST_HALTED: begin
        state_next = ST_HALTED;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output / datapath next values
  always_comb begin
    pc_next            = pc;
    flush_pending_next = flush_pending;
    flush_target_next  = flush_target;
    instr_next         = instr;
    instr_pc_next      = instr_pc;
    misalign_next      = 1'b0;
    imem_req_next      = (state_next == ST_REQ);
    instr_valid_next   = (state_next == ST_HOLD);

    unique case (state)
      ST_IDLE: begin
        if (trap_take) begin
          pc_next = tgt_aligned;
        end
      end
      ST_REQ: begin
        if (imem_ack) begin
          // Outstanding request completes; a flush steers the next request instead of decode
          if (tgt_valid) begin
            pc_next            = tgt_aligned;
            flush_pending_next = 1'b0;
          end else if (flush_pending) begin
            pc_next            = flush_target;
            flush_pending_next = 1'b0;
          end else begin
            instr_next    = imem_rdata;
            instr_pc_next = pc;
          end
        end else if (tgt_valid) begin
          flush_pending_next = 1'b1;
          flush_target_next  = tgt_aligned;
        end
      end
      ST_HOLD: begin
        if (tgt_valid) begin
          pc_next = tgt_aligned;
        end else if (!stall && !halt) begin
          pc_next = pc + XLEN'(INSTR_BYTES);
        end
      end
      ST_HALTED: begin
        pc_next = pc;
      end
      default: begin
        pc_next = pc;
      end
    endcase

    if (tgt_valid && ((state == ST_REQ) || (state == ST_HOLD))) begin
      misalign_next = tgt_misaligned;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc            <= RESET_VEC;
      flush_pending <= 1'b0;
      flush_target  <= '0;
      instr         <= '0;
      instr_pc      <= '0;
      misalign      <= 1'b0;
      imem_req      <= 1'b0;
      instr_valid   <= 1'b0;
    end else begin
      pc            <= pc_next;
      flush_pending <= flush_pending_next;
      flush_target  <= flush_target_next;
      instr         <= instr_next;
      instr_pc      <= instr_pc_next;
      misalign      <= misalign_next;
      imem_req      <= imem_req_next;
      instr_valid   <= instr_valid_next;
    end
  end

`ifdef PC_SEQ_TRAP_EN
  // Exception PC captures the instruction held when the trap is taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      epc <= '0;
    end else if (trap_take) begin
      epc <= instr_pc;
    end
  end
`endif

endmodule
